// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM channel slice.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  localparam int PWM_W        = 16;
  localparam int SYNC_DEFAULT = 2;

endpackage

// File: rtl/slow_clk_edge_detect.sv
// Synchronizes the divided clock into i_clk and turns each rising edge into a
// one-cycle tick; ticks stay masked until the synchronizer has refilled after reset.
module slow_clk_edge_detect
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_slow_clk,
  output logic o_tick
);

  localparam int             GUARD     = SYNC_STAGES + 1;
  localparam int             GW        = $clog2(GUARD + 1);
  localparam logic [GW-1:0]  GUARD_CNT = GW'(GUARD);
  localparam logic [GW-1:0]  GUARD_ONE = {{(GW-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   edge_r;
  logic [GW-1:0]          guard_r;
  logic                   armed_s;

  // Synchronizer chain, edge history and post-reset guard counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_r  <= {SYNC_STAGES{1'b0}};
      edge_r  <= 1'b0;
      guard_r <= {GW{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_slow_clk};
      edge_r <= sync_r[SYNC_STAGES-1];
      if (guard_r != GUARD_CNT) begin
        guard_r <= guard_r + GUARD_ONE;
      end else begin
        guard_r <= guard_r;
      end
    end
  end

  // A slow clock already high at reset release must not look like a rising edge.
  assign armed_s = (guard_r == GUARD_CNT);
  assign o_tick  = sync_r[SYNC_STAGES-1] & ~edge_r & armed_s;

endmodule

// File: rtl/pwm_channel_core.sv
// Single-channel PWM: double-buffered period/duty, tick-driven counter and
// registered glitch-free output.
module pwm_channel_core
  import pwm_pkg::*;
#(
  parameter int W           = PWM_W,
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_slow_clk,
  input  logic         i_en,
  input  logic         i_wr,
  input  logic [W-1:0] i_period,
  input  logic [W-1:0] i_duty,
  output logic         o_pwm,
  output logic         o_cycle_end,
  output logic         o_pending,
  output logic         o_busy
);

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  pwm_state_e   state_r, state_next_s;
  logic [W-1:0] ct_r, ct_next_s;
  logic [W-1:0] act_period_r, per_next_s;
  logic [W-1:0] act_duty_r, duty_next_s;
  logic [W-1:0] sh_period_r, sh_per_next_s;
  logic [W-1:0] sh_duty_r, sh_duty_next_s;
  logic         pending_r, pend_next_s;
  logic         pwm_r, cycle_end_r, busy_r;
  logic         pwm_next_s;
  logic         tick_s, wrap_s, boundary_s;
  logic [W-1:0] last_ct_s;

  slow_clk_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_slow_clk (i_slow_clk),
    .o_tick     (tick_s)
  );

  // Only meaningful in RUN, where the active period is never zero.
  assign last_ct_s = act_period_r - ONE_W;

  // Shadow/active hand-over, next-state, counter and output decode.
  always_comb begin
    state_next_s   = state_r;
    ct_next_s      = ct_r;
    per_next_s     = act_period_r;
    duty_next_s    = act_duty_r;
    sh_per_next_s  = sh_period_r;
    sh_duty_next_s = sh_duty_r;
    pend_next_s    = pending_r;

    wrap_s     = (state_r == RUN) && tick_s && (ct_r == last_ct_s);
    boundary_s = (state_r == IDLE) || wrap_s;

    if (boundary_s) begin
      if (i_wr) begin
        per_next_s  = i_period;
        duty_next_s = i_duty;
        pend_next_s = 1'b0;
      end else if (pending_r) begin
        per_next_s  = sh_period_r;
        duty_next_s = sh_duty_r;
        pend_next_s = 1'b0;
      end else begin
        pend_next_s = 1'b0;
      end
    end else begin
      if (i_wr) begin
        sh_per_next_s  = i_period;
        sh_duty_next_s = i_duty;
        pend_next_s    = 1'b1;
      end else begin
        pend_next_s = pending_r;
      end
    end

    case (state_r)
      IDLE: begin
        ct_next_s = ZERO_W;
        if (i_en && (per_next_s != ZERO_W)) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (wrap_s) begin
          ct_next_s = ZERO_W;
          if (!i_en || (per_next_s == ZERO_W)) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = RUN;
          end
        end else if (tick_s) begin
          ct_next_s = ct_r + ONE_W;
        end else begin
          ct_next_s = ct_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        ct_next_s    = ZERO_W;
      end
    endcase

    pwm_next_s = (state_next_s == RUN) && (ct_next_s < duty_next_s);
  end

  // State, buffers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= IDLE;
      ct_r         <= ZERO_W;
      act_period_r <= ZERO_W;
      act_duty_r   <= ZERO_W;
      sh_period_r  <= ZERO_W;
      sh_duty_r    <= ZERO_W;
      pending_r    <= 1'b0;
      pwm_r        <= 1'b0;
      cycle_end_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      ct_r         <= ct_next_s;
      act_period_r <= per_next_s;
      act_duty_r   <= duty_next_s;
      sh_period_r  <= sh_per_next_s;
      sh_duty_r    <= sh_duty_next_s;
      pending_r    <= pend_next_s;
      pwm_r        <= pwm_next_s;
      cycle_end_r  <= wrap_s;
      busy_r       <= (state_next_s == RUN);
    end
  end

  assign o_pwm       = pwm_r;
  assign o_cycle_end = cycle_end_r;
  assign o_pending   = pending_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_pwm_channel_core.sv
// Directed and randomized stimulus for pwm_channel_core, checked every cycle
// against a behavioural model of period/duty/tick rules.
module tb_pwm_channel_core;

  localparam int W = 16;
  localparam int S = 2;

  logic         i_clk;
  logic         i_rst;
  logic         i_slow_clk;
  logic         i_en;
  logic         i_wr;
  logic [W-1:0] i_period;
  logic [W-1:0] i_duty;
  logic         o_pwm;
  logic         o_cycle_end;
  logic         o_pending;
  logic         o_busy;

  int checks;
  int errors;

  // Model: running flag, position in period, active/shadow values.
  bit m_run, m_pend, m_ce;
  int m_pos, m_per, m_duty, m_sp, m_sd;
  int since_rst;
  bit hist [0:S];
  int shalf, sphase;
  bit force_hi;
  bit found;

  pwm_channel_core #(.W(W), .SYNC_STAGES(S)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_slow_clk  (i_slow_clk),
    .i_en        (i_en),
    .i_wr        (i_wr),
    .i_period    (i_period),
    .i_duty      (i_duty),
    .o_pwm       (o_pwm),
    .o_cycle_end (o_cycle_end),
    .o_pending   (o_pending),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // A slow-clock rise seen at edge n-S (low at n-S-1) is a tick at edge n,
  // provided S+2 edges have passed since reset.
  function automatic bit next_tick();
    return (since_rst + 1 >= S + 2) && hist[S-1] && !hist[S];
  endfunction

  task automatic model_edge(input bit rst, input bit en, input bit wr,
                            input int per, input int dty, input bit s);
    bit tick, wrap, boundary;
    if (rst) begin
      m_run = 0; m_pend = 0; m_ce = 0;
      m_pos = 0; m_per = 0; m_duty = 0; m_sp = 0; m_sd = 0;
      since_rst = 0;
      for (int k = 0; k <= S; k++) hist[k] = 0;
    end else begin
      tick = next_tick();
      if (since_rst < 1000) since_rst++;
      wrap = m_run && tick && (m_pos == m_per - 1);
      boundary = !m_run || wrap;
      if (boundary) begin
        if (wr) begin m_per = per; m_duty = dty; m_pend = 0; end
        else if (m_pend) begin m_per = m_sp; m_duty = m_sd; m_pend = 0; end
      end else if (wr) begin
        m_sp = per; m_sd = dty; m_pend = 1;
      end
      if (!m_run) begin
        m_pos = 0;
        if (en && m_per != 0) m_run = 1;
      end else if (wrap) begin
        m_pos = 0;
        if (!en || m_per == 0) m_run = 0;
      end else if (tick) begin
        m_pos++;
      end
      m_ce = wrap;
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_true(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed 0 expected 1", tag);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit wr, input int per, input int dty);
    bit s;
    bit exp_pwm;
    @(negedge i_clk);
    if (force_hi) begin
      s = 1;
    end else begin
      s = (sphase < shalf);
      sphase = (sphase + 1) % (2 * shalf);
    end
    i_rst = rst; i_en = en; i_wr = wr;
    i_period = W'(per); i_duty = W'(dty); i_slow_clk = s;
    @(posedge i_clk);
    model_edge(rst, en, wr, per, dty, s);
    #1;
    exp_pwm = m_run && (m_pos < m_duty);
    check("pwm", o_pwm, exp_pwm);
    check("cycle_end", o_cycle_end, m_ce);
    check("pending", o_pending, m_pend);
    check("busy", o_busy, m_run);
  endtask

  task automatic idle_run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, en, 0, 0, 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    shalf = 4; sphase = 0; force_hi = 0;
    i_rst = 1; i_en = 0; i_wr = 0; i_period = '0; i_duty = '0; i_slow_clk = 0;
    model_edge(1, 0, 0, 0, 0, 0);

    // Reset state
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

    // Basic P=4 D=1 with slow clock = i_clk/8
    step(0, 1, 1, 4, 1);
    idle_run(110, 1);

    // Mid-period duty update: pending until the wrap
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && m_pos == 1 && !next_tick()) found = 1;
      else step(0, 1, 0, 0, 0);
    end
    expect_true("wait_mid_period", found);
    step(0, 1, 1, 4, 3);
    check("pending_after_wr", o_pending, 1'b1);
    idle_run(80, 1);

    // Duty/period edge cases
    step(0, 1, 1, 4, 0);  idle_run(70, 1);
    step(0, 1, 1, 4, 4);  idle_run(70, 1);
    step(0, 1, 1, 4, 9);  idle_run(70, 1);
    step(0, 1, 1, 0, 2);  idle_run(70, 1);
    check("p0_busy", o_busy, 1'b0);

    // Drop enable at ct=1: period completes
    step(0, 1, 1, 4, 2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && m_pos == 1) found = 1;
      else step(0, 1, 0, 0, 0);
    end
    expect_true("wait_ct1", found);
    idle_run(50, 0);
    check("en_drop_busy", o_busy, 1'b0);

    // Reset at ct=2 with slow clock held high
    step(0, 1, 1, 4, 3);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && m_pos == 2) found = 1;
      else step(0, 1, 0, 0, 0);
    end
    expect_true("wait_ct2", found);
    force_hi = 1;
    step(1, 1, 0, 0, 0);
    check("rst_pwm", o_pwm, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    step(0, 1, 1, 4, 2);
    idle_run(30, 1);
    force_hi = 0; sphase = 0;
    idle_run(40, 1);

    // Write coinciding with a wrap tick goes straight to active
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && next_tick() && m_pos == m_per - 1) found = 1;
      else step(0, 1, 0, 0, 0);
    end
    expect_true("wait_wrap", found);
    step(0, 1, 1, 3, 2);
    check("wrap_wr_pending", o_pending, 1'b0);
    idle_run(60, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit r_rst, r_en, r_wr;
      int r_per, r_dty;
      if ($urandom_range(0, 39) == 0) begin
        shalf = $urandom_range(1, 5);
        sphase = 0;
      end
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_wr  = ($urandom_range(0, 11) == 0);
      r_per = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
      r_dty = $urandom_range(0, 9);
      step(r_rst, r_en, r_wr, r_per, r_dty);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
